// File: rtl/aes_block_framer.sv
// rtl/aes_block_framer.sv - packs 32-bit plaintext words into AES blocks and sequences the fixed-latency core
module aes_block_framer #(
    parameter int NK      = 4,
    parameter int NR      = 10,
    parameter int LATENCY = NR + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [NK*32-1:0] key_in,
    output logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [127:0]     core_state,
    output logic [NK*32-1:0] core_key,
    input  logic [127:0]     core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic [15:0]      block_cnt
);

    localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       word_cnt;
    logic [WCW-1:0]   wait_cnt;
    logic [95:0]      pack;
    logic             in_fire;
    logic             out_fire;
    logic             last_word;
    logic             wait_done;

    assign in_ready  = (state == COLLECT);
    assign key_ready = (state == COLLECT) && (word_cnt == 2'd0);
    assign busy      = (state != COLLECT);

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_word = in_fire && (word_cnt == 2'd3);
    assign wait_done = (state == WAIT) && (wait_cnt == WCW'(LATENCY - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_word) state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = HOLD;
            HOLD:    if (out_fire)  state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt   <= 2'd0;
            wait_cnt   <= '0;
            pack       <= '0;
            core_state <= '0;
            core_key   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            block_cnt  <= 16'd0;
        end else begin
            if (in_fire) begin
                case (word_cnt)
                    2'd0:    pack[95:64] <= in_data;
                    2'd1:    pack[63:32] <= in_data;
                    2'd2:    pack[31:0]  <= in_data;
                    default: ;
                endcase
                word_cnt <= word_cnt + 2'd1;
            end
            // Word 3 bypasses the pack register so the block reaches the core on the same edge.
            if (last_word) begin
                core_state <= {pack, in_data};
                wait_cnt   <= '0;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_done) begin
                out_data  <= core_result;
                out_valid <= 1'b1;
            end
            if (out_fire) begin
                out_valid <= 1'b0;
                block_cnt <= block_cnt + 16'd1;
            end
            // A key written with word 0 of a block applies to that block.
            if (key_load && key_ready) begin
                core_key <= key_in;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_framer.sv
// tb/tb_aes_block_framer.sv - scoreboard bench for aes_block_framer with a fixed-latency core model
module tb_aes_block_framer;

    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int LATENCY = NR + 1;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2      = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT3      = 128'hdeadbeef0badf00dcafef00d12345678;

    logic           clk;
    logic           rst_n;
    logic           key_load;
    logic [127:0]   key_in;
    logic           key_ready;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_data;
    logic [127:0]   core_state;
    logic [127:0]   core_key;
    logic [127:0]   core_result;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;
    logic [15:0]    block_cnt;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             w3_cyc = 0;
    logic [127:0]   exp_q[$];
    logic [127:0]   exp_cs;
    logic [127:0]   model_key;
    logic [15:0]    exp_cnt;
    logic           cnt_pending;
    logic           prev_ov;
    logic [127:0]   prev_od;
    logic [127:0]   pipe [LATENCY-1];

    aes_block_framer #(.NK(NK), .NR(NR), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .core_state(core_state), .core_key(core_key),
        .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .block_cnt(block_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext, anything else to a keyed mix.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
        if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return {s[95:0], s[127:96]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Result is valid during the cycle before edge E+LATENCY, stale before that.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= core_f(core_state, core_key);
        for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_result = pipe[LATENCY-2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        cnt_pending = 1'b0;
        prev_ov     = 1'b0;
        prev_od     = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (cnt_pending) begin
                    chk("block_cnt", 128'(block_cnt), 128'(exp_cnt));
                    cnt_pending = 1'b0;
                end
                if (out_valid && !prev_ov)
                    chk("latency", 128'(cyc - w3_cyc), 128'(LATENCY));
                if (out_valid && prev_ov)
                    chk("out_data_stable", out_data, prev_od);
                if (busy && !out_valid) begin
                    chk("wait_core_state", core_state, exp_cs);
                    chk("wait_core_key", core_key, model_key);
                end
                if (busy) begin
                    chk("busy_in_ready", 128'(in_ready), 128'(0));
                    chk("busy_key_ready", 128'(key_ready), 128'(0));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%h expected=none", out_data);
                    end else begin
                        chk("out_data", out_data, exp_q.pop_front());
                    end
                    exp_cnt     = exp_cnt + 16'd1;
                    cnt_pending = 1'b1;
                end
            end else begin
                cnt_pending = 1'b0;
            end
            prev_ov = out_valid;
            prev_od = out_data;
        end
    end

    task automatic send_word(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d expected=<300", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        key_load = 1'b0;
    endtask

    // kl_at: 0 no key pulse, 1 key_load with word 0, 2 key_load between words 1 and 2 (ignored).
    task automatic send_block(input logic [127:0] pt, input bit gaps, input int kl_at,
                              input logic [127:0] k);
        for (int w = 0; w < 4; w++) begin
            if (gaps) repeat ($urandom_range(3)) @(negedge clk);
            if (w == 0 && kl_at == 1) begin
                key_load  = 1'b1;
                key_in    = k;
                model_key = k;
            end
            if (w == 2 && kl_at == 2) begin
                chk("key_ready_mid", 128'(key_ready), 128'(0));
                key_load = 1'b1;
                key_in   = k;
                @(negedge clk);
                key_load = 1'b0;
            end
            send_word(pt[127-32*w -: 32]);
        end
        w3_cyc = cyc;
        exp_cs = pt;
        exp_q.push_back(core_f(pt, model_key));
    endtask

    task automatic load_key(input logic [127:0] k);
        chk("key_ready_idle", 128'(key_ready), 128'(1));
        key_load  = 1'b1;
        key_in    = k;
        model_key = k;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (busy || out_valid) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d expected=<500", t);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_key = '0;
        exp_cs    = '0;
        exp_cnt   = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_core_state", core_state, 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_block_cnt", 128'(block_cnt), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_key_ready", 128'(key_ready), 128'(1));

        load_key(FIPS_KEY);
        send_block(FIPS_PT, 1'b0, 0, '0);
        wait_idle();

        for (int r = 0; r < 2; r++) begin
            send_block(FIPS_PT, 1'b1, 0, '0);
            wait_idle();
        end

        out_ready = 1'b0;
        send_block(PT2, 1'b0, 0, '0);
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        chk("stall_out_valid_seen", 128'(out_valid), 128'(1));
        in_valid = 1'b1;
        in_data  = 32'hbadc0ffe;
        repeat (20) begin
            @(negedge clk);
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wait_idle();

        send_block(PT2, 1'b0, 2, KEY2);
        key_load = 1'b1;
        key_in   = KEY2;
        @(negedge clk);
        key_load = 1'b0;
        wait_idle();
        send_block(PT2, 1'b0, 1, KEY2);
        wait_idle();

        send_block(PT3, 1'b0, 0, '0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_core_state", core_state, 128'(0));
        chk("midrst_block_cnt", 128'(block_cnt), 128'(0));
        chk("midrst_core_key", core_key, 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        void'(exp_q.pop_back());
        exp_cnt   = 16'd0;
        model_key = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_key(FIPS_KEY);
        send_block(FIPS_PT, 1'b1, 0, '0);
        wait_idle();

        force dut.block_cnt = 16'hffff;
        #1;
        release dut.block_cnt;
        exp_cnt = 16'hffff;
        @(negedge clk);
        send_block(PT3, 1'b0, 0, '0);
        wait_idle();
        chk("wrap_block_cnt", 128'(block_cnt), 128'(0));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
